// File: rtl/demux1_2_sched.sv
// demux1_2_sched: sequencing controller for the 1:2 demux path.
// Round-robin distribution of a valid/ready stream into two registered
// output slots in bursts of BURST words. An output that is blocked is skipped,
// and a software force can override the target. Per-output delivery counters
// are kept for the status bus.
module demux1_2_sched #(
  parameter int W     = 8,
  parameter int BURST = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] IN_DATA,
  output logic         Y1_VALID,
  input  logic         Y1_READY,
  output logic [W-1:0] Y1_DATA,
  output logic         Y2_VALID,
  input  logic         Y2_READY,
  output logic [W-1:0] Y2_DATA,
  input  logic         FORCE_EN,
  input  logic         FORCE_SEL,
  output logic         S,
  output logic [15:0]  CNT1,
  output logic [15:0]  CNT2
);

  typedef enum logic {
    SEL1 = 1'b0,
    SEL2 = 1'b1
  } sel_state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  sel_state_t state;
  sel_state_t state_nxt;
  logic [3:0] burst_cnt;
  logic [3:0] burst_nxt;

  logic slot1_can;
  logic slot2_can;
  logic other_valid;
  logic accept;
  logic load1;
  logic load2;
  logic drain1;
  logic drain2;
  logic skip;

  // Handshake terms: the input is ready exactly when the targeted slot can
  // take a word. This never looks at IN_VALID, so there is no valid->ready path.
  always_comb begin
    slot1_can   = !Y1_VALID || Y1_READY;
    slot2_can   = !Y2_VALID || Y2_READY;
    IN_READY    = (state == SEL2) ? slot2_can : slot1_can;
    other_valid = (state == SEL2) ? Y1_VALID : Y2_VALID;
    accept      = IN_VALID && IN_READY;
    load1       = accept && (state == SEL1);
    load2       = accept && (state == SEL2);
    drain1      = Y1_VALID && Y1_READY;
    drain2      = Y2_VALID && Y2_READY;
    skip        = !IN_READY && !other_valid;
  end

  // Target selection: the force wins. Otherwise a full burst toggles the
  // target, and a blocked target is abandoned when the other slot is empty.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (FORCE_EN) begin
      state_nxt = FORCE_SEL ? SEL2 : SEL1;
      burst_nxt = '0;
    end else if (accept) begin
      if (burst_cnt == BURST_LAST) begin
        state_nxt = (state == SEL1) ? SEL2 : SEL1;
        burst_nxt = '0;
      end else begin
        burst_nxt = burst_cnt + 4'd1;
      end
    end else if (skip) begin
      state_nxt = (state == SEL1) ? SEL2 : SEL1;
      burst_nxt = '0;
    end
  end

  // State register for the target select and the burst position.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= SEL1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  assign S = (state == SEL2);

  // Output slot 1. A load takes priority over a drain, so a slot that is
  // drained and loaded in the same cycle stays full with the new word.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Y1_VALID <= 1'b0;
      Y1_DATA  <= '0;
    end else if (load1) begin
      Y1_VALID <= 1'b1;
      Y1_DATA  <= IN_DATA;
    end else if (drain1) begin
      Y1_VALID <= 1'b0;
    end
  end

  // Output slot 2, with the same load-over-drain priority as slot 1.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Y2_VALID <= 1'b0;
      Y2_DATA  <= '0;
    end else if (load2) begin
      Y2_VALID <= 1'b1;
      Y2_DATA  <= IN_DATA;
    end else if (drain2) begin
      Y2_VALID <= 1'b0;
    end
  end

  // Delivery counters advance once per drain and wrap naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      CNT1 <= '0;
      CNT2 <= '0;
    end else begin
      if (drain1) CNT1 <= CNT1 + 16'd1;
      if (drain2) CNT2 <= CNT2 + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux1_2_sched.sv
// Testbench for demux1_2_sched: directed scenarios plus a randomized run
// checked against a behavioural model of the distribution rules.
module tb_demux1_2_sched;
  localparam int W     = 8;
  localparam int BURST = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         y1_valid;
  logic         y1_ready = 1'b0;
  logic [W-1:0] y1_data;
  logic         y2_valid;
  logic         y2_ready = 1'b0;
  logic [W-1:0] y2_data;
  logic         force_en = 1'b0;
  logic         force_sel = 1'b0;
  logic         s;
  logic [15:0]  cnt1;
  logic [15:0]  cnt2;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit           m_s;
  int           m_burst;
  bit           m_v1, m_v2;
  logic [W-1:0] m_d1, m_d2;
  int           m_c1, m_c2;
  logic [W-1:0] acc1[$], acc2[$], obs1[$], obs2[$];

  demux1_2_sched #(.W(W), .BURST(BURST)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .Y1_VALID(y1_valid), .Y1_READY(y1_ready), .Y1_DATA(y1_data),
    .Y2_VALID(y2_valid), .Y2_READY(y2_ready), .Y2_DATA(y2_data),
    .FORCE_EN(force_en), .FORCE_SEL(force_sel), .S(s),
    .CNT1(cnt1), .CNT2(cnt2)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return m_s ? (!m_v2 || y2_ready) : (!m_v1 || y1_ready);
  endfunction

  // Advance one clock: log DUT deliveries, update the model, sample #1 after edge.
  task automatic step();
    bit rdy, acc, dr1, dr2, other_v;
    @(negedge clk);
    if (rst_n && y1_valid && y1_ready) obs1.push_back(y1_data);
    if (rst_n && y2_valid && y2_ready) obs2.push_back(y2_data);
    rdy     = model_ready();
    acc     = in_valid && rdy;
    dr1     = m_v1 && y1_ready;
    dr2     = m_v2 && y2_ready;
    other_v = m_s ? m_v1 : m_v2;
    if (!rst_n) begin
      m_s = 0; m_burst = 0; m_v1 = 0; m_v2 = 0;
      m_d1 = '0; m_d2 = '0; m_c1 = 0; m_c2 = 0;
    end else begin
      if (acc && !m_s) begin
        m_v1 = 1; m_d1 = in_data; acc1.push_back(in_data);
      end else if (dr1) m_v1 = 0;
      if (acc && m_s) begin
        m_v2 = 1; m_d2 = in_data; acc2.push_back(in_data);
      end else if (dr2) m_v2 = 0;
      if (dr1) m_c1 = (m_c1 + 1) % 65536;
      if (dr2) m_c2 = (m_c2 + 1) % 65536;
      if (force_en) begin
        m_s = force_sel; m_burst = 0;
      end else if (acc) begin
        if (m_burst + 1 >= BURST) begin m_s = !m_s; m_burst = 0; end
        else m_burst = m_burst + 1;
      end else if (!rdy && !other_v) begin
        m_s = !m_s; m_burst = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    total++; if (s !== 1'b0) begin bad++; $display("[TB] FAIL reset_s got=%0b want=0", s); end
    total++; if ({y1_valid, y2_valid} !== 2'b00) begin bad++; $display("[TB] FAIL reset_valid got=%b want=00", {y1_valid, y2_valid}); end
    total++; if ({y1_data, y2_data} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data got=%h want=0000", {y1_data, y2_data}); end
    total++; if ({cnt1, cnt2} !== 32'h0) begin bad++; $display("[TB] FAIL reset_cnt got=%h want=0", {cnt1, cnt2}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] e1[4] = '{8'h01, 8'h02, 8'h05, 8'h06};
    logic [W-1:0] e2[4] = '{8'h03, 8'h04, 8'h07, 8'h08};
    obs1.delete(); obs2.delete();
    y1_ready = 1; y2_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 8'(i);
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rr_in_ready word=%0d got=%0b want=1", i, in_ready); end
    end
    in_valid = 0;
    step(); step();
    total++; if (obs1.size() != 4 || obs2.size() != 4) begin bad++; $display("[TB] FAIL rr_sizes got=%0d/%0d want=4/4", obs1.size(), obs2.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (obs1[i] !== e1[i]) begin bad++; $display("[TB] FAIL rr_y1[%0d] got=%h want=%h", i, obs1[i], e1[i]); end
        total++; if (obs2[i] !== e2[i]) begin bad++; $display("[TB] FAIL rr_y2[%0d] got=%h want=%h", i, obs2[i], e2[i]); end
      end
    end
    total++; if (cnt1 !== 16'd4 || cnt2 !== 16'd4) begin bad++; $display("[TB] FAIL rr_cnt got=%0d/%0d want=4/4", cnt1, cnt2); end
  endtask

  task automatic test_backpressure();
    y1_ready = 0; y2_ready = 0;
    force_en = 1; force_sel = 1; in_valid = 0;
    step();
    force_sel = 0; in_valid = 1; in_data = 8'h5A;
    step();
    in_data = 8'hA5;
    step();
    force_en = 0; in_valid = 0;
    total++; if (y2_valid !== 1'b1 || y2_data !== 8'h5A) begin bad++; $display("[TB] FAIL bp_y2_load got=%0b/%h want=1/5a", y2_valid, y2_data); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (y1_valid !== 1'b1 || y1_data !== 8'hA5) begin bad++; $display("[TB] FAIL bp_hold cyc=%0d got=%0b/%h want=1/a5", i, y1_valid, y1_data); end
      total++; if (in_ready !== 1'b0 || s !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready cyc=%0d got rdy=%0b s=%0b want 0/0", i, in_ready, s); end
    end
    y1_ready = 1;
    step();
    y1_ready = 0;
    total++; if (y1_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b want=0", y1_valid); end
    total++; if (cnt1 !== 16'd5) begin bad++; $display("[TB] FAIL bp_cnt1 got=%0d want=5", cnt1); end
  endtask

  task automatic test_skip();
    y2_ready = 1;
    step();
    y2_ready = 0; in_valid = 1; in_data = 8'h11;
    step();
    total++; if (y1_valid !== 1'b1 || y1_data !== 8'h11 || s !== 1'b0) begin bad++; $display("[TB] FAIL skip_setup got=%0b/%h s=%0b want=1/11 s=0", y1_valid, y1_data, s); end
    in_data = 8'h22; y2_ready = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL skip_in_ready got=%0b want=0", in_ready); end
    step();
    total++; if (s !== 1'b1) begin bad++; $display("[TB] FAIL skip_toggle got=%0b want=1", s); end
    step();
    total++; if (y2_valid !== 1'b1 || y2_data !== 8'h22 || s !== 1'b1) begin bad++; $display("[TB] FAIL skip_land got=%0b/%h s=%0b want=1/22 s=1", y2_valid, y2_data, s); end
    in_data = 8'h33;
    step();
    in_valid = 0;
    total++; if (s !== 1'b0) begin bad++; $display("[TB] FAIL skip_burst_restart got=%0b want=0", s); end
  endtask

  task automatic test_force();
    int c1_before, c2_before;
    force_en = 1; force_sel = 1; in_valid = 0; y2_ready = 1;
    step();
    total++; if (s !== 1'b1) begin bad++; $display("[TB] FAIL force_s got=%0b want=1", s); end
    obs2.delete();
    c1_before = m_c1; c2_before = m_c2;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 8'(8'hC0 + i);
      step();
      total++; if (s !== 1'b1) begin bad++; $display("[TB] FAIL force_hold word=%0d got=%0b want=1", i, s); end
    end
    in_valid = 0;
    step(); step();
    total++; if (obs2.size() != 6) begin bad++; $display("[TB] FAIL force_count got=%0d want=6", obs2.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (obs2[i] !== 8'(8'hC0 + i)) begin bad++; $display("[TB] FAIL force_y2[%0d] got=%h want=%h", i, obs2[i], 8'(8'hC0 + i)); end
      end
    end
    total++; if (cnt2 !== 16'(c2_before + 6)) begin bad++; $display("[TB] FAIL force_cnt2 got=%0d want=%0d", cnt2, 16'(c2_before + 6)); end
    total++; if (cnt1 !== 16'(c1_before)) begin bad++; $display("[TB] FAIL force_cnt1 got=%0d want=%0d", cnt1, 16'(c1_before)); end
    force_en = 0; y2_ready = 0;
  endtask

  task automatic test_reset_mid();
    force_en = 1; force_sel = 0;
    step();
    force_en = 0; y1_ready = 1; in_valid = 1; in_data = 8'h44;
    step();
    y1_ready = 0; in_valid = 0;
    total++; if (y1_valid !== 1'b1 || y1_data !== 8'h44) begin bad++; $display("[TB] FAIL rmid_setup got=%0b/%h want=1/44", y1_valid, y1_data); end
    rst_n = 0;
    step();
    rst_n = 1;
    total++; if ({s, y1_valid, y2_valid} !== 3'b000 || {y1_data, y2_data} !== 16'h0) begin bad++; $display("[TB] FAIL rmid_state got s/v=%b data=%h want 000/0000", {s, y1_valid, y2_valid}, {y1_data, y2_data}); end
    total++; if ({cnt1, cnt2} !== 32'h0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_cnt got=%h rdy=%0b want=0 rdy=1", {cnt1, cnt2}, in_ready); end
    in_valid = 1; in_data = 8'h55;
    step();
    in_valid = 0;
    total++; if (y1_valid !== 1'b1 || y1_data !== 8'h55 || y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_next got y1=%0b/%h y2v=%0b want 1/55 0", y1_valid, y1_data, y2_valid); end
  endtask

  task automatic test_random();
    y1_ready = 1; y2_ready = 1; in_valid = 0; force_en = 0;
    step(); step();
    acc1.delete(); acc2.delete(); obs1.delete(); obs2.delete();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      y1_ready  = ($urandom_range(0, 2) != 0);
      y2_ready  = ($urandom_range(0, 2) != 0);
      force_en  = ($urandom_range(0, 11) == 0);
      force_sel = 1'($urandom);
      step();
      total++; if (s !== m_s) begin bad++; $display("[TB] FAIL rnd_s cyc=%0d got=%0b want=%0b", i, s, m_s); end
      total++; if (in_ready !== model_ready()) begin bad++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", i, in_ready, model_ready()); end
      total++; if (y1_valid !== m_v1 || y1_data !== m_d1) begin bad++; $display("[TB] FAIL rnd_y1 cyc=%0d got=%0b/%h want=%0b/%h", i, y1_valid, y1_data, m_v1, m_d1); end
      total++; if (y2_valid !== m_v2 || y2_data !== m_d2) begin bad++; $display("[TB] FAIL rnd_y2 cyc=%0d got=%0b/%h want=%0b/%h", i, y2_valid, y2_data, m_v2, m_d2); end
      total++; if (cnt1 !== 16'(m_c1) || cnt2 !== 16'(m_c2)) begin bad++; $display("[TB] FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, cnt1, cnt2, m_c1, m_c2); end
    end
    in_valid = 0; force_en = 0; y1_ready = 1; y2_ready = 1;
    step(); step();
    total++; if (obs1.size() != acc1.size() || obs2.size() != acc2.size()) begin bad++; $display("[TB] FAIL rnd_delivered got=%0d/%0d want=%0d/%0d", obs1.size(), obs2.size(), acc1.size(), acc2.size()); end
    else begin
      for (int i = 0; i < obs1.size(); i++) begin
        total++; if (obs1[i] !== acc1[i]) begin bad++; $display("[TB] FAIL rnd_order_y1[%0d] got=%h want=%h", i, obs1[i], acc1[i]); end
      end
      for (int i = 0; i < obs2.size(); i++) begin
        total++; if (obs2[i] !== acc2[i]) begin bad++; $display("[TB] FAIL rnd_order_y2[%0d] got=%h want=%h", i, obs2[i], acc2[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    rst_n = 0; in_valid = 0; force_en = 0;
    step();
    rst_n = 1;
    obs1.delete(); obs2.delete(); acc1.delete(); acc2.delete();
    force_en = 1; force_sel = 0; y1_ready = 1; y2_ready = 0; in_valid = 1;
    for (int i = 0; i < 65536; i++) begin
      in_data = 8'(i);
      step();
    end
    total++; if (cnt1 !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_pre got=%h want=ffff", cnt1); end
    in_valid = 0;
    step();
    total++; if (cnt1 !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_zero got=%h want=0000", cnt1); end
    total++; if (y1_valid !== 1'b0 || cnt2 !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_tail got y1v=%0b cnt2=%h want 0/0000", y1_valid, cnt2); end
    force_en = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip();
    test_force();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
